// File: rtl/cnt_port_arbiter_pkg.sv
// Shared types for the counter-table port-A arbiter: requester ids, read tags, defaults.
// Holds the round-robin helpers used by the top-level arbiter.
// No logic of its own; consumed via import cnt_port_arbiter_pkg::*.
package cnt_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 512;
  // Tag id field is sized for the widest supported table address.
  localparam int TAG_ID_W   = 32;

  typedef enum logic [1:0] {
    SRC_W = 2'd0,
    SRC_R = 2'd1,
    SRC_S = 2'd2
  } src_e;

  typedef struct packed {
    src_e                src;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Pick the first requester at or after ptr in W,R,S order.
  // Walks from lowest to highest priority so the last hit wins.
  function automatic src_e rr_pick(input logic [2:0] req, input src_e ptr);
    src_e       pick;
    int         idx;
    logic [1:0] idx2;
    pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx  = (int'(ptr) + k) % 3;
      idx2 = idx[1:0];
      if (req[idx2]) pick = src_e'(idx2);
    end
    return pick;
  endfunction

  // Requester that follows the granted one; S is skipped when sweep is not built.
  function automatic src_e rr_next(input src_e g, input bit sweep_en);
    case (g)
      SRC_W:   return SRC_R;
      SRC_R:   return sweep_en ? SRC_S : SRC_W;
      default: return SRC_W;
    endcase
  endfunction

endpackage

// File: rtl/cnt_sweep_gen.sv
// Sweep FSM: walks addresses 0..LAST_ID through the arbiter, then waits for the last return.
// Latency: request asserted the cycle after sweep_start; done pulses when the LAST_ID tag exits.
// Backpressure: address only advances on an S grant; sweep_start ignored while busy.
module cnt_sweep_gen
  import cnt_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LAST_ID = 16383
) (
  input  logic              asclk,
  input  logic              areset,
  input  logic              sweep_start,
  input  logic              s_gnt,
  input  logic              last_exit,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              sweep_busy,
  output logic              sweep_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next-state: start, step on each grant, stop at LAST_ID (no wrap), finish on last return.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_RUN;
          addr_d  = '0;
        end
      end
      ST_RUN: begin
        if (s_gnt) begin
          if (addr_q == ADDR_W'(LAST_ID)) state_d = ST_DRAIN;
          else                             addr_d  = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (last_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and address registers; reset aborts any sweep in progress.
  always_ff @(posedge asclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign s_req      = (state_q == ST_RUN);
  assign s_addr     = addr_q;
  assign sweep_busy = (state_q != ST_IDLE);
  // Same-cycle pulse with the final sweep_vld.
  assign sweep_done = (state_q == ST_DRAIN) && last_exit;

endmodule

// File: rtl/cnt_port_arbiter.sv
// Round-robin arbiter (W,R,S) for counter-table port A; read returns tagged through an RD_LAT pipe.
// Latency: grant/rdy combinational; read data returned RD_LAT cycles after grant, in grant order.
// Backpressure: rdy only when granted; return sinks always accept. Sweep built under CNT_ARB_SWEEP_EN.
module cnt_port_arbiter
  import cnt_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 2,
  parameter int LAST_ID = 16383
) (
  input  logic              asclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] w_cnt_id,
  input  logic [DATA_W-1:0] w_cnt_data,
  input  logic              w_cnt_vld,
  output logic              w_cnt_rdy,
  input  logic [ADDR_W-1:0] r_cnt_id,
  input  logic              r_cnt_vld,
  output logic              r_cnt_rdy,
  output logic              r_cnt_data_vld,
  output logic [DATA_W-1:0] r_cnt_data,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_vld,
  output logic [ADDR_W-1:0] sweep_id,
  output logic [DATA_W-1:0] sweep_data,
  output logic              sweep_done,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta
);

`ifdef CNT_ARB_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic              s_req;
  logic [ADDR_W-1:0] s_addr;
  logic [2:0]        req;
  logic              gnt_any;
  logic              rd_gnt;
  src_e              gnt_src;
  src_e              ptr_q, ptr_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  tag_t              tag_q [RD_LAT];
  tag_t              tag_d [RD_LAT];
  logic              exit_vld;
  tag_t              exit_tag;
  logic              last_exit;
  logic              unused_tag_bits;

  // Requests are masked during reset so no rdy can assert asynchronously.
  assign req     = areset ? 3'b000 : {s_req, r_cnt_vld, w_cnt_vld};
  assign gnt_any = |req;
  assign gnt_src = rr_pick(req, ptr_q);

  assign w_cnt_rdy = gnt_any && (gnt_src == SRC_W);
  assign r_cnt_rdy = gnt_any && (gnt_src == SRC_R);
  assign rd_gnt    = gnt_any && (gnt_src != SRC_W);

  // Port-A drive: the granted requester's address; write data always from W.
  always_comb begin
    bram_wea   = w_cnt_rdy;
    bram_dina  = w_cnt_data;
    bram_addra = w_cnt_id;
    case (gnt_src)
      SRC_R:   bram_addra = r_cnt_id;
      SRC_S:   bram_addra = s_addr;
      default: bram_addra = w_cnt_id;
    endcase
  end

  // Next pointer and tag-pipe shift; each read grant enters at stage 0.
  always_comb begin
    ptr_d        = gnt_any ? rr_next(gnt_src, SWEEP_EN) : ptr_q;
    tag_vld_d    = '0;
    tag_vld_d[0] = rd_gnt;
    tag_d[0]     = '{src: gnt_src, id: TAG_ID_W'(bram_addra)};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_d[i]     = tag_q[i-1];
    end
  end

  // Pointer and tag pipeline registers; reset empties the pipe and parks the pointer on W.
  always_ff @(posedge asclk or posedge areset) begin
    if (areset) begin
      ptr_q     <= SRC_W;
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign exit_vld        = tag_vld_q[RD_LAT-1];
  assign exit_tag        = tag_q[RD_LAT-1];
  assign last_exit       = exit_vld && (exit_tag.src == SRC_S) && (exit_tag.id == TAG_ID_W'(LAST_ID));
  assign unused_tag_bits = ^exit_tag.id;

  // Return data is the raw port-A output; the strobes say who it belongs to.
  assign r_cnt_data_vld = exit_vld && (exit_tag.src == SRC_R);
  assign r_cnt_data     = bram_douta;
  assign sweep_data     = bram_douta;

`ifdef CNT_ARB_SWEEP_EN
  logic s_gnt;
  assign s_gnt = gnt_any && (gnt_src == SRC_S);

  cnt_sweep_gen #(
    .ADDR_W  (ADDR_W),
    .LAST_ID (LAST_ID)
  ) u_sweep (
    .asclk       (asclk),
    .areset      (areset),
    .sweep_start (sweep_start),
    .s_gnt       (s_gnt),
    .last_exit   (last_exit),
    .s_req       (s_req),
    .s_addr      (s_addr),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  assign sweep_vld = exit_vld && (exit_tag.src == SRC_S);
  assign sweep_id  = exit_tag.id[ADDR_W-1:0];
`else
  logic unused_sweep;
  assign unused_sweep = sweep_start ^ last_exit;
  assign s_req        = 1'b0;
  assign s_addr       = '0;
  assign sweep_busy   = 1'b0;
  assign sweep_done   = 1'b0;
  assign sweep_vld    = 1'b0;
  assign sweep_id     = '0;
`endif

endmodule

// File: tb/tb_cnt_port_arbiter.sv
// Directed bench for cnt_port_arbiter with a 2-cycle port-A memory model.
// Table-driven W/R arbitration and return checks, then sweep and reset sequences.
// Sweep sequences are selected by CNT_ARB_SWEEP_EN, matching the DUT build.
module tb_cnt_port_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 512;
  localparam int LAT = 2;
  localparam int LID = 3;

  logic          asclk = 1'b0;
  logic          areset = 1'b0;
  logic [AW-1:0] w_cnt_id = '0;
  logic [DW-1:0] w_cnt_data = '0;
  logic          w_cnt_vld = 1'b0;
  logic          w_cnt_rdy;
  logic [AW-1:0] r_cnt_id = '0;
  logic          r_cnt_vld = 1'b0;
  logic          r_cnt_rdy;
  logic          r_cnt_data_vld;
  logic [DW-1:0] r_cnt_data;
  logic          sweep_start = 1'b0;
  logic          sweep_busy;
  logic          sweep_vld;
  logic [AW-1:0] sweep_id;
  logic [DW-1:0] sweep_data;
  logic          sweep_done;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic [DW-1:0] bram_douta;

  int total = 0;
  int bad   = 0;

  always #5 asclk = ~asclk;

  cnt_port_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .RD_LAT (LAT), .LAST_ID (LID)
  ) dut (
    .asclk (asclk), .areset (areset),
    .w_cnt_id (w_cnt_id), .w_cnt_data (w_cnt_data), .w_cnt_vld (w_cnt_vld), .w_cnt_rdy (w_cnt_rdy),
    .r_cnt_id (r_cnt_id), .r_cnt_vld (r_cnt_vld), .r_cnt_rdy (r_cnt_rdy),
    .r_cnt_data_vld (r_cnt_data_vld), .r_cnt_data (r_cnt_data),
    .sweep_start (sweep_start), .sweep_busy (sweep_busy), .sweep_vld (sweep_vld),
    .sweep_id (sweep_id), .sweep_data (sweep_data), .sweep_done (sweep_done),
    .bram_wea (bram_wea), .bram_addra (bram_addra), .bram_dina (bram_dina), .bram_douta (bram_douta)
  );

  // Port-A memory model: 64 entries, read data two cycles after the address.
  logic          mem_clr = 1'b1;
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] rd_p0, rd_p1;
  always @(posedge asclk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= DW'(32'h1000 + i);
    end else if (bram_wea) begin
      mem[bram_addra[5:0]] <= bram_dina;
    end
    rd_p0 <= mem[bram_addra[5:0]];
    rd_p1 <= rd_p0;
  end
  assign bram_douta = rd_p1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge asclk);
    #1;
  endtask

  task automatic drive(input int wv, input int wid, input int wd, input int rv, input int rid, input int ss);
    w_cnt_vld   = (wv != 0);
    w_cnt_id    = AW'(wid);
    w_cnt_data  = DW'(wd);
    r_cnt_vld   = (rv != 0);
    r_cnt_id    = AW'(rid);
    sweep_start = (ss != 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Expected sweep data: entry 3 was rewritten to 'h33 by the table phase.
  function automatic logic [DW-1:0] sw_exp(input int id);
    return (id == 3) ? DW'(32'h33) : DW'(32'h1000 + id);
  endfunction

  // Expected grant in the saturated window: 0=W, 1=R, 2=S.
  function automatic int eg(input int k);
`ifdef CNT_ARB_SWEEP_EN
    if (k <= 11) return k % 3;
`endif
    return k % 2;
  endfunction

  typedef struct {
    logic          w_vld;
    logic [AW-1:0] w_id;
    logic [DW-1:0] w_dat;
    logic          r_vld;
    logic [AW-1:0] r_id;
    logic          ew;
    logic          er;
    logic [AW-1:0] ea;
    logic          erv;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl [14];

  task automatic row(input int i, input int wv, input int wid, input int wd, input int rv, input int rid,
                     input int ew, input int er, input int ea, input int erv, input int ed);
    tbl[i].w_vld = (wv != 0);
    tbl[i].w_id  = AW'(wid);
    tbl[i].w_dat = DW'(wd);
    tbl[i].r_vld = (rv != 0);
    tbl[i].r_id  = AW'(rid);
    tbl[i].ew    = (ew != 0);
    tbl[i].er    = (er != 0);
    tbl[i].ea    = AW'(ea);
    tbl[i].erv   = (erv != 0);
    tbl[i].ed    = DW'(ed);
  endtask

  initial begin
    //   i  wv wid wd     rv rid  ew er ea  erv ed
    row( 0, 0, 0,  0,     0, 0,   0, 0, 0,  0, 0);
    row( 1, 1, 5,  'hAB,  0, 0,   1, 0, 5,  0, 0);
    row( 2, 0, 0,  0,     1, 5,   0, 1, 5,  0, 0);
    row( 3, 1, 7,  'h77,  1, 9,   1, 0, 7,  0, 0);
    row( 4, 1, 7,  'h77,  1, 9,   0, 1, 9,  1, 'hAB);
    row( 5, 1, 7,  'h77,  1, 9,   1, 0, 7,  0, 0);
    row( 6, 1, 7,  'h77,  1, 9,   0, 1, 9,  1, 'h1009);
    row( 7, 1, 9,  'h99,  0, 0,   1, 0, 9,  0, 0);
    row( 8, 1, 3,  'h33,  0, 0,   1, 0, 3,  1, 'h1009);
    row( 9, 0, 0,  0,     1, 9,   0, 1, 9,  0, 0);
    row(10, 0, 0,  0,     1, 3,   0, 1, 3,  0, 0);
    row(11, 1, 12, 'hC,   1, 7,   1, 0, 12, 1, 'h99);
    row(12, 0, 0,  0,     0, 0,   0, 0, 0,  1, 'h33);
    row(13, 0, 0,  0,     0, 0,   0, 0, 0,  0, 0);

    // Reset state, with a write request held to show rdy is masked.
    #1 areset = 1'b1;
    w_cnt_vld = 1'b1;
    #1;
    chk1("rst_w_rdy", w_cnt_rdy, 1'b0);
    chk1("rst_r_rdy", r_cnt_rdy, 1'b0);
    chk1("rst_wea", bram_wea, 1'b0);
    chk1("rst_rdv", r_cnt_data_vld, 1'b0);
    chk1("rst_busy", sweep_busy, 1'b0);
    chk1("rst_svld", sweep_vld, 1'b0);
    chk1("rst_done", sweep_done, 1'b0);
    w_cnt_vld = 1'b0;
    tick();
    tick();
    mem_clr = 1'b0;
    areset  = 1'b0;

    // Table phase: W/R arbitration, port-A drive and read returns.
    for (int i = 0; i < 14; i++) begin
      drive(int'(tbl[i].w_vld), int'(tbl[i].w_id), 0, int'(tbl[i].r_vld), int'(tbl[i].r_id), 0);
      w_cnt_data = tbl[i].w_dat;
      @(negedge asclk);
      chk1($sformatf("t%0d_w_rdy", i), w_cnt_rdy, tbl[i].ew);
      chk1($sformatf("t%0d_r_rdy", i), r_cnt_rdy, tbl[i].er);
      chk1($sformatf("t%0d_wea", i), bram_wea, tbl[i].ew);
      if (tbl[i].ew || tbl[i].er) chkw($sformatf("t%0d_addra", i), DW'(bram_addra), DW'(tbl[i].ea));
      if (tbl[i].ew) chkw($sformatf("t%0d_dina", i), bram_dina, tbl[i].w_dat);
      chk1($sformatf("t%0d_rdv", i), r_cnt_data_vld, tbl[i].erv);
      if (tbl[i].erv) chkw($sformatf("t%0d_rdat", i), r_cnt_data, tbl[i].ed);
      tick();
    end

`ifdef CNT_ARB_SWEEP_EN
    // Uncontended sweep; a second start while busy must be ignored.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, 0, (k == 0 || k == 2) ? 1 : 0);
      @(negedge asclk);
      chk1($sformatf("s%0d_busy", k), sweep_busy, (k >= 1 && k <= 6));
      chk1($sformatf("s%0d_vld", k), sweep_vld, (k >= 3 && k <= 6));
      chk1($sformatf("s%0d_done", k), sweep_done, (k == 6));
      if (k >= 3 && k <= 6) begin
        chkw($sformatf("s%0d_id", k), DW'(sweep_id), DW'(k - 3));
        chkw($sformatf("s%0d_dat", k), sweep_data, sw_exp(k - 3));
      end
      tick();
    end
`endif

    // Saturated W and R with a sweep_start pulse.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1, 60, 'hEE, 1, 50, (k == 0) ? 1 : 0);
      @(negedge asclk);
      chk1($sformatf("c%0d_w_rdy", k), w_cnt_rdy, (eg(k) == 0));
      chk1($sformatf("c%0d_r_rdy", k), r_cnt_rdy, (eg(k) == 1));
      chk1($sformatf("c%0d_rdv", k), r_cnt_data_vld, (k >= 2 && eg(k - 2) == 1));
      if (k >= 2 && eg(k - 2) == 1) chkw($sformatf("c%0d_rdat", k), r_cnt_data, DW'(32'h1032));
`ifdef CNT_ARB_SWEEP_EN
      if (eg(k) == 2) begin
        chk1($sformatf("c%0d_s_wea", k), bram_wea, 1'b0);
        chkw($sformatf("c%0d_s_addr", k), DW'(bram_addra), DW'((k - 2) / 3));
      end
      chk1($sformatf("c%0d_busy", k), sweep_busy, (k >= 1 && k <= 13));
      chk1($sformatf("c%0d_svld", k), sweep_vld, (k == 4 || k == 7 || k == 10 || k == 13));
      chk1($sformatf("c%0d_done", k), sweep_done, (k == 13));
      if (k == 4 || k == 7 || k == 10 || k == 13) begin
        chkw($sformatf("c%0d_sid", k), DW'(sweep_id), DW'((k - 4) / 3));
        chkw($sformatf("c%0d_sdat", k), sweep_data, sw_exp((k - 4) / 3));
      end
`else
      chk1($sformatf("c%0d_busy", k), sweep_busy, 1'b0);
      chk1($sformatf("c%0d_svld", k), sweep_vld, 1'b0);
      chk1($sformatf("c%0d_done", k), sweep_done, 1'b0);
      chkw($sformatf("c%0d_sid", k), DW'(sweep_id), '0);
`endif
      tick();
    end

`ifdef CNT_ARB_SWEEP_EN
    // Reset while sweep id 2 is in the tag pipe, then restart from id 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, (k == 0) ? 1 : 0);
      tick();
    end
    r_cnt_vld = 1'b1;
    areset    = 1'b1;
    #1;
    chk1("ab_busy", sweep_busy, 1'b0);
    chk1("ab_svld", sweep_vld, 1'b0);
    chk1("ab_done", sweep_done, 1'b0);
    chk1("ab_r_rdy", r_cnt_rdy, 1'b0);
    chk1("ab_rdv", r_cnt_data_vld, 1'b0);
    chk1("ab_wea", bram_wea, 1'b0);
    r_cnt_vld = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge asclk);
      chk1($sformatf("ab%0d_svld", k), sweep_vld, 1'b0);
      chk1($sformatf("ab%0d_done", k), sweep_done, 1'b0);
      chk1($sformatf("ab%0d_rdv", k), r_cnt_data_vld, 1'b0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, (k == 0) ? 1 : 0);
      @(negedge asclk);
      chk1($sformatf("rs%0d_svld", k), sweep_vld, (k == 3 || k == 4));
      if (k == 3) begin
        chkw("rs_id0", DW'(sweep_id), '0);
        chkw("rs_dat0", sweep_data, sw_exp(0));
      end
      tick();
    end
`endif

    drive(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
